// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped instruction cache.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_READY,
    ST_REFILL_REQ,
    ST_REFILL_WAIT,
    ST_RESPOND
  } state_e;

  localparam int unsigned BYTE_OFFSET_W = 2;

  function automatic int unsigned offset_w(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned pc_width,
                                        input int unsigned lines,
                                        input int unsigned words_per_line);
    return pc_width - BYTE_OFFSET_W - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/instr_cache_array.sv
// Data/tag/valid storage: combinational read, synchronous write, single-cycle bulk invalidate.
module instr_cache_array #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned OFF_W      = 2,
  parameter int unsigned TAG_W      = 24,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [IDX_W-1:0]      rd_idx_i,
  input  logic [OFF_W-1:0]      rd_off_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic                  rd_valid_o,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [OFF_W-1:0]      wr_off_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  tag_we_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic                  set_valid_i,
  input  logic                  clear_all_i
);

  localparam int unsigned LINES = 2 ** IDX_W;
  localparam int unsigned WORDS = 2 ** (IDX_W + OFF_W);

  logic [DATA_WIDTH-1:0] data_q [WORDS];
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [LINES-1:0]      valid_q;

  assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
    end
    if (tag_we_i) begin
      tag_q[wr_idx_i] <= tag_i;
    end
  end

  // Bulk clear wins over a same-cycle set so a flush can never be undone by a fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, blocking instruction cache with line refill over a simple request/beat memory port.
module instr_cache
  import cache_pkg::*;
#(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [PC_WIDTH-1:0]   req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [PC_WIDTH-1:0]   rsp_addr,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [PC_WIDTH-1:0]   mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned OFF_W   = offset_w(WORDS_PER_LINE);
  localparam int unsigned IDX_W   = index_w(LINES);
  localparam int unsigned TAG_W   = tag_w(PC_WIDTH, LINES, WORDS_PER_LINE);
  localparam int unsigned IDX_LSB = BYTE_OFFSET_W + OFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

  state_e state_q, state_d;

  logic [PC_WIDTH-1:0]   addr_q;
  logic [PC_WIDTH-1:0]   mem_req_addr_q;
  logic [PC_WIDTH-1:0]   rsp_addr_q;
  logic [DATA_WIDTH-1:0] rsp_instr_q;
  logic                  rsp_valid_q;
  logic [OFF_W-1:0]      beat_q;
  logic                  flushed_q;
  logic [31:0]           hit_cnt_q;
  logic [31:0]           miss_cnt_q;

  logic [IDX_W-1:0]      rd_idx;
  logic [OFF_W-1:0]      rd_off;
  logic [TAG_W-1:0]      lookup_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_valid;
  logic                  accept, hit, wr_en, fill_done, set_valid;

  // Lookups use the live PC while idle and the latched PC for the refill response.
  assign rd_idx     = (state_q == ST_READY) ? req_addr[TAG_LSB-1:IDX_LSB] : addr_q[TAG_LSB-1:IDX_LSB];
  assign rd_off     = (state_q == ST_READY) ? req_addr[IDX_LSB-1:BYTE_OFFSET_W]
                                            : addr_q[IDX_LSB-1:BYTE_OFFSET_W];
  assign lookup_tag = req_addr[PC_WIDTH-1:TAG_LSB];

  assign hit       = rd_valid && (rd_tag == lookup_tag);
  assign accept    = req_valid && req_ready;
  assign wr_en     = (state_q == ST_REFILL_WAIT) && mem_rsp_valid;
  assign fill_done = wr_en && (beat_q == '1);
  assign set_valid = fill_done && !flush && !flushed_q;

  instr_cache_array #(
    .IDX_W      (IDX_W),
    .OFF_W      (OFF_W),
    .TAG_W      (TAG_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i       (clk),
    .rst_ni      (rst),
    .rd_idx_i    (rd_idx),
    .rd_off_i    (rd_off),
    .rd_data_o   (rd_data),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .wr_en_i     (wr_en),
    .wr_idx_i    (addr_q[TAG_LSB-1:IDX_LSB]),
    .wr_off_i    (beat_q),
    .wr_data_i   (mem_rsp_data),
    .tag_we_i    (fill_done),
    .tag_i       (addr_q[PC_WIDTH-1:TAG_LSB]),
    .set_valid_i (set_valid),
    .clear_all_i (flush)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_READY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_READY:       if (accept && !hit) state_d = ST_REFILL_REQ;
      ST_REFILL_REQ:  if (mem_req_ready) state_d = ST_REFILL_WAIT;
      ST_REFILL_WAIT: if (fill_done) state_d = ST_RESPOND;
      ST_RESPOND:     state_d = ST_READY;
      default:        state_d = ST_READY;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    rsp_valid     = rsp_valid_q;
    rsp_instr     = rsp_instr_q;
    rsp_addr      = rsp_addr_q;
    unique case (state_q)
      ST_READY:      req_ready = !flush;
      ST_REFILL_REQ: mem_req_valid = 1'b1;
      ST_RESPOND: begin
        rsp_valid = 1'b1;
        rsp_instr = rd_data;
        rsp_addr  = addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q         <= '0;
      mem_req_addr_q <= '0;
      rsp_addr_q     <= '0;
      rsp_instr_q    <= '0;
      rsp_valid_q    <= 1'b0;
      beat_q         <= '0;
      flushed_q      <= 1'b0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      rsp_valid_q <= accept && hit;
      if (accept && hit) begin
        rsp_instr_q <= rd_data;
        rsp_addr_q  <= req_addr;
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (accept && !hit) begin
        addr_q         <= req_addr;
        mem_req_addr_q <= {req_addr[PC_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
        flushed_q      <= 1'b0;
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if ((state_q == ST_REFILL_REQ) && mem_req_ready) begin
        beat_q <= '0;
      end else if (wr_en) begin
        beat_q <= beat_q + 1'b1;
      end
      // A flush that lands anywhere in the refill leaves the refilled line invalid.
      if (flush && (state_q != ST_READY)) flushed_q <= 1'b1;
    end
  end

  assign mem_req_addr = mem_req_addr_q;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001: Parameter PC_WIDTH, default 32, byte address width of requests.
REQ-002: Parameter DATA_WIDTH, default 32, instruction/word width.
REQ-003: Parameter LINES, default 16, number of direct-mapped lines (power of 2).
REQ-004: Parameter WORDS_PER_LINE, default 4, words per line (power of 2).
REQ-005: clk  in  1  sole clock; all state updates on rising edge.
REQ-006: rst  in  1  asynchronous, active-low reset.
REQ-007: req_valid  in  1  fetch presents a PC this cycle.
REQ-008: req_addr  in  PC_WIDTH  fetch PC; bits [1:0] ignored.
REQ-009: req_ready  out  1  request accepted when req_valid && req_ready.
REQ-010: rsp_valid  out  1  single-cycle pulse; rsp_instr/rsp_addr valid.
REQ-011: rsp_instr  out  DATA_WIDTH  instruction for rsp_addr.
REQ-012: rsp_addr  out  PC_WIDTH  PC of the accepted request being answered.
REQ-013: flush  in  1  invalidate all lines.
REQ-014: mem_req_valid / mem_req_ready  out / in  1  refill request handshake.
REQ-015: mem_req_addr  out  PC_WIDTH  line-aligned refill address.
REQ-016: mem_rsp_valid  in  1; mem_rsp_data  in  DATA_WIDTH; one word per beat, ascending order.
REQ-017: hit_count, miss_count  out  32  performance counters.

Function
REQ-018: Address split (defaults): offset = addr[3:2], index = addr[7:4], tag = addr[PC_WIDTH-1:8]; widths derived from parameters.
REQ-019: FSM states READY, REFILL_REQ, REFILL_WAIT, RESPOND; req_ready = 1 only in READY with flush low.
REQ-020: READY, accepted request, line valid and tag equal (hit): rsp_valid = 1 next cycle with stored word; stay READY; back-to-back hits sustain one response per cycle.
REQ-021: READY, accepted request, miss: latch address, go REFILL_REQ; no response that cycle or next.
REQ-022: REFILL_REQ: mem_req_valid = 1, mem_req_addr = latched addr with offset and byte bits zero, held stable until mem_req_ready; then REFILL_WAIT, beat counter = 0.
REQ-023: REFILL_WAIT: each mem_rsp_valid writes word[beat] into the line and increments beat; on beat WORDS_PER_LINE-1 write tag, set valid, go RESPOND.
REQ-024: RESPOND: rsp_valid = 1 with requested word from the refilled line, rsp_addr = latched addr; return to READY next cycle.
REQ-025: mem_rsp_valid outside REFILL_WAIT is ignored.
REQ-026: flush in READY clears all valid bits in that cycle and takes priority over a simultaneous req_valid (not accepted).
REQ-027: flush during REFILL_REQ/REFILL_WAIT/RESPOND clears all valid bits; refill completes and the response is delivered, but the refilled line is left invalid.
REQ-028: Response on hit is registered (latency 1); rsp_valid has no backpressure.
REQ-029: hit_count increments on each accepted hit, miss_count on each accepted miss; both saturate at 0xFFFF_FFFF.

Reset
REQ-030: rst low asynchronously forces state READY, all valid bits 0, beat 0, counters 0, rsp_valid 0, rsp_instr 0, rsp_addr 0, mem_req_valid 0, mem_req_addr 0.
REQ-031: Reset mid-refill abandons the refill; no response is produced; data/tag arrays need not be reset.

Structure
REQ-032: Package cache_pkg holds the state enum and localparam-derived OFFSET/INDEX/TAG width functions.
REQ-033: One sub-module instr_cache_array holds data/tag/valid storage (combinational read, synchronous write, bulk valid clear).

Verification
REQ-034: Memory model returns data = address. Reset, request 0x100 -> miss, mem_req_addr 0x100, 4 beats, rsp_instr 0x100, miss_count 1.
REQ-035: Then requests 0x104, 0x108, 0x10C on consecutive cycles -> three rsp_valid pulses on consecutive cycles, data 0x104/0x108/0x10C, hit_count 3.
REQ-036: Request 0x200 (same index as 0x100, other tag) -> miss, refill at 0x200; then 0x100 -> miss again.
REQ-037: flush asserted with req_valid at 0x104 after fill -> req_ready 0 that cycle; next request 0x104 -> miss.
REQ-038: flush asserted during REFILL_WAIT beat 2 for 0x300 -> rsp_instr 0x300 delivered; re-request 0x300 -> miss.
REQ-039: rst low during REFILL_WAIT -> all outputs at reset values, no rsp_valid; request 0x100 after release -> miss.
